stage_id: RTL and testbench

- Instruction-decode stage of the br32 5-stage pipeline. Sits directly downstream of the fetch stage and upstream of execute.
- Holds the IF/ID pipeline register and decodes fields. Reads the register file, forwarding from EX where needed.
- Resolves branches and jumps in ID and returns the redirect to fetch. Detects load-use hazards and stalls fetch.

---
 rtl/br32_pkg.sv | 37 +++
 rtl/id_hazard.sv | 44 ++++
 rtl/stage_id.sv | 138 +++++++++++++
 tb/tb_stage_id.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/br32_pkg.sv
// Shared definitions for the br32 pipeline: opcodes, instruction field
// positions and the decoded-instruction bundle handed from ID to EX.
package br32_pkg;

    localparam logic [5:0] OP_LOAD_BASE = 6'h20;
    localparam logic [5:0] OP_BEQ       = 6'h30;
    localparam logic [5:0] OP_BNE       = 6'h31;
    localparam logic [5:0] OP_JAL       = 6'h32;
    localparam logic [5:0] OP_JALR      = 6'h33;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS1_MSB = 20;
    localparam int RS1_LSB = 16;
    localparam int RS2_MSB = 15;
    localparam int RS2_LSB = 11;
    localparam int IMM_MSB = 15;
    localparam int J_MSB   = 25;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } decoded_t;

    // Loads occupy the aligned block 6'h20..6'h27.
    function automatic logic is_load_op(input logic [5:0] op);
        return op[5:3] == OP_LOAD_BASE[5:3];
    endfunction

endpackage

// File: rtl/id_hazard.sv
// Operand forwarding from EX and load-use detection for the decode stage.
// Purely combinational.
module id_hazard
    import br32_pkg::*;
(
    input  logic        v,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic        use_rs1,
    input  logic        use_rs2,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        load_use
);

    // A load's result is not available until after EX, so only ALU results forward.
    function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] rf_data,
                                        input logic ex_v, input logic ex_ld,
                                        input logic [4:0] ex_d, input logic [31:0] ex_res);
        if (addr == 5'd0)
            return 32'd0;
        else if (ex_v && !ex_ld && ex_d == addr)
            return ex_res;
        else
            return rf_data;
    endfunction

    logic hit_rs1;
    logic hit_rs2;

    assign op_a = fwd(rs1_addr, rs1_data, ex_valid, ex_load, ex_rd, ex_result);
    assign op_b = fwd(rs2_addr, rs2_data, ex_valid, ex_load, ex_rd, ex_result);

    assign hit_rs1  = use_rs1 && (ex_rd == rs1_addr);
    assign hit_rs2  = use_rs2 && (ex_rd == rs2_addr);
    assign load_use = v && ex_valid && ex_load && (ex_rd != 5'd0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/stage_id.sv
// br32 instruction-decode stage: IF/ID register, register read with EX
// forwarding, load-use stall and branch/jump resolution.
module stage_id
    import br32_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exn,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        if_bubble,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    output logic        stall,
    output logic        branch,
    output logic [31:0] branch_dest,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [4:0]  id_rd,
    output logic [31:0] id_a,
    output logic [31:0] id_b,
    output logic [31:0] id_imm
);

    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v     <= 1'b0;
            pc    <= 32'd0;
            instr <= NOP_INSTR;
        end else if (exn) begin
            v <= 1'b0;
        end else if (!stall) begin
            v     <= !if_bubble;
            pc    <= if_pc;
            instr <= if_instr;
        end
    end

    logic [5:0]  op;
    logic        is_beq, is_bne, is_jal, is_jalr, two_src;
    logic [31:0] op_a, op_b;
    logic        load_use;
    logic [31:0] pc_plus4, imm_sext, br_target, jal_target, target;
    logic        taken;

    assign op      = instr[OP_MSB:OP_LSB];
    assign is_beq  = (op == OP_BEQ);
    assign is_bne  = (op == OP_BNE);
    assign is_jal  = (op == OP_JAL);
    assign is_jalr = (op == OP_JALR);
    // Branches and JALR read their sources from the rd/rs1 field positions.
    assign two_src = is_beq || is_bne || is_jalr;

    assign rf_rs1_addr = two_src ? instr[RD_MSB:RD_LSB]   : instr[RS1_MSB:RS1_LSB];
    assign rf_rs2_addr = two_src ? instr[RS1_MSB:RS1_LSB] : instr[RS2_MSB:RS2_LSB];

    id_hazard u_hazard (
        .v         (v),
        .rs1_addr  (rf_rs1_addr),
        .rs2_addr  (rf_rs2_addr),
        .use_rs1   (!is_jal),
        .use_rs2   (!is_jal),
        .rs1_data  (rf_rs1_data),
        .rs2_data  (rf_rs2_data),
        .ex_valid  (ex_valid),
        .ex_load   (ex_load),
        .ex_rd     (ex_rd),
        .ex_result (ex_result),
        .op_a      (op_a),
        .op_b      (op_b),
        .load_use  (load_use)
    );

    assign stall      = load_use;
    assign pc_plus4   = pc + 32'd4;
    assign imm_sext   = {{16{instr[IMM_MSB]}}, instr[IMM_MSB:0]};
    assign br_target  = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign jal_target = pc_plus4 + {{4{instr[J_MSB]}}, instr[J_MSB:0], 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = 32'd0;
        if (is_beq) begin
            taken  = (op_a == op_b);
            target = br_target;
        end else if (is_bne) begin
            taken  = (op_a != op_b);
            target = br_target;
        end else if (is_jal) begin
            taken  = 1'b1;
            target = jal_target;
        end else if (is_jalr) begin
            taken  = 1'b1;
            target = op_b & ~32'd3;
        end
    end

    assign branch      = v && !stall && !exn && taken;
    assign branch_dest = branch ? target : 32'd0;

    decoded_t dec;

    always_comb begin
        dec       = '0;
        dec.pc    = pc;
        dec.instr = NOP_INSTR;
        dec.valid = v && !stall && !exn;
        if (dec.valid) begin
            dec.instr = instr;
            dec.rd    = instr[RD_MSB:RD_LSB];
            dec.a     = (is_jal || is_jalr) ? pc_plus4 : op_a;
            dec.b     = op_b;
            dec.imm   = imm_sext;
        end
    end

    assign id_valid = dec.valid;
    assign id_pc    = dec.pc;
    assign id_instr = dec.instr;
    assign id_rd    = dec.rd;
    assign id_a     = dec.a;
    assign id_b     = dec.b;
    assign id_imm   = dec.imm;

endmodule

// File: tb/tb_stage_id.sv
// Directed self-checking bench for stage_id with a small behavioural regfile.
module tb_stage_id;

    logic        clk = 1'b0;
    logic        rst;
    logic        exn;
    logic [31:0] if_pc, if_instr;
    logic        if_bubble;
    logic        ex_valid, ex_load;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        stall, branch;
    logic [31:0] branch_dest;
    logic        id_valid;
    logic [31:0] id_pc, id_instr;
    logic [4:0]  id_rd;
    logic [31:0] id_a, id_b, id_imm;

    logic [31:0] regs [32];
    int total = 0;
    int bad = 0;

    assign rf_rs1_data = regs[rf_rs1_addr];
    assign rf_rs2_data = regs[rf_rs2_addr];

    always #5 clk = ~clk;

    stage_id dut (
        .clk(clk), .rst(rst), .exn(exn),
        .if_pc(if_pc), .if_instr(if_instr), .if_bubble(if_bubble),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_rd(ex_rd), .ex_result(ex_result),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .stall(stall), .branch(branch), .branch_dest(branch_dest),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_rd(id_rd),
        .id_a(id_a), .id_b(id_b), .id_imm(id_imm)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a word to IF, clock it into IF/ID, settle away from the edge.
    task automatic load_instr(input logic [31:0] pc, input logic [31:0] ins);
        if_pc     = pc;
        if_instr  = ins;
        if_bubble = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
        regs[0]   = 32'hBAD0_0000;
        rst       = 1'b1;
        exn       = 1'b0;
        if_pc     = 32'd0;
        if_instr  = 32'd0;
        if_bubble = 1'b1;
        ex_valid  = 1'b0;
        ex_load   = 1'b0;
        ex_rd     = 5'd0;
        ex_result = 32'd0;
        #1;
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_branch", {31'd0, branch}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ALU forwarding from EX
        ex_valid = 1'b1; ex_load = 1'b0; ex_rd = 5'd3; ex_result = 32'hDEAD_BEEF;
        load_instr(32'h10, enc_r(6'h00, 5'd1, 5'd3, 5'd2));
        check("fwd_valid", {31'd0, id_valid}, 32'd1);
        check("fwd_rs1_addr", {27'd0, rf_rs1_addr}, 32'd3);
        check("fwd_a", id_a, 32'hDEAD_BEEF);
        check("fwd_b", id_b, 32'h1002);
        check("fwd_rd", {27'd0, id_rd}, 32'd1);
        check("fwd_pc", id_pc, 32'h10);
        ex_rd = 5'd0;
        #1;
        check("nofwd_rd0_r3", id_a, 32'h1003);
        load_instr(32'h14, enc_r(6'h00, 5'd1, 5'd0, 5'd2));
        check("r0_reads_zero", id_a, 32'h0);

        // Load encoding: sign-extended immediate
        ex_valid = 1'b0;
        load_instr(32'h20, enc_i(6'h24, 5'd8, 5'd9, 16'h8000));
        check("imm_sext", id_imm, 32'hFFFF_8000);
        check("load_no_branch", {31'd0, branch}, 32'd0);

        // Load-use: one-cycle stall
        ex_valid = 1'b1; ex_load = 1'b1; ex_rd = 5'd5;
        load_instr(32'h30, enc_r(6'h00, 5'd1, 5'd5, 5'd2));
        check("lu_stall", {31'd0, stall}, 32'd1);
        check("lu_id_valid", {31'd0, id_valid}, 32'd0);
        check("lu_id_instr", id_instr, 32'h0);
        check("lu_id_rd", {27'd0, id_rd}, 32'd0);
        if_pc = 32'h34; if_instr = enc_r(6'h00, 5'd9, 5'd9, 5'd9);
        @(posedge clk);
        #1 ex_valid = 1'b0; ex_load = 1'b0;
        #1;
        check("lu_after_stall", {31'd0, stall}, 32'd0);
        check("lu_after_valid", {31'd0, id_valid}, 32'd1);
        check("lu_after_pc", id_pc, 32'h30);
        check("lu_after_a", id_a, 32'h1005);

        // BEQ taken backwards to itself, then not taken
        regs[6] = 32'h55; regs[7] = 32'h55;
        load_instr(32'h100, enc_i(6'h30, 5'd6, 5'd7, 16'hFFFF));
        check("beq_rs1_addr", {27'd0, rf_rs1_addr}, 32'd6);
        check("beq_rs2_addr", {27'd0, rf_rs2_addr}, 32'd7);
        check("beq_taken", {31'd0, branch}, 32'd1);
        check("beq_dest", branch_dest, 32'h100);
        regs[7] = 32'h56;
        #1;
        check("beq_not_taken", {31'd0, branch}, 32'd0);
        check("beq_dest_zero", branch_dest, 32'h0);
        load_instr(32'h100, enc_i(6'h31, 5'd6, 5'd7, 16'h0002));
        check("bne_taken", {31'd0, branch}, 32'd1);
        check("bne_dest", branch_dest, 32'h10C);

        // JALR and JAL link and target
        regs[4] = 32'h1237;
        load_instr(32'h40, enc_i(6'h33, 5'd0, 5'd4, 16'h0000));
        check("jalr_branch", {31'd0, branch}, 32'd1);
        check("jalr_dest", branch_dest, 32'h1234);
        check("jalr_link", id_a, 32'h44);
        load_instr(32'h200, {6'h32, 26'd3});
        check("jal_dest", branch_dest, 32'h210);
        check("jal_link", id_a, 32'h204);
        exn = 1'b1;
        #1;
        check("jal_exn_branch", {31'd0, branch}, 32'd0);
        check("jal_exn_valid", {31'd0, id_valid}, 32'd0);
        exn = 1'b0;

        // Flush during a load-use stall
        ex_valid = 1'b1; ex_load = 1'b1; ex_rd = 5'd5;
        load_instr(32'h50, enc_r(6'h00, 5'd1, 5'd5, 5'd2));
        check("exn_pre_stall", {31'd0, stall}, 32'd1);
        exn = 1'b1;
        if_pc = 32'h60; if_instr = enc_r(6'h00, 5'd1, 5'd2, 5'd3); if_bubble = 1'b0;
        @(posedge clk);
        #1 exn = 1'b0;
        #1;
        check("exn_flushed_valid", {31'd0, id_valid}, 32'd0);
        check("exn_flushed_stall", {31'd0, stall}, 32'd0);
        check("exn_flushed_instr", id_instr, 32'h0);
        @(posedge clk);
        #1;
        check("exn_capture_valid", {31'd0, id_valid}, 32'd1);
        check("exn_capture_pc", id_pc, 32'h60);
        check("exn_capture_instr", id_instr, enc_r(6'h00, 5'd1, 5'd2, 5'd3));
        ex_valid = 1'b0; ex_load = 1'b0;

        // Asynchronous reset with a taken jump in ID
        load_instr(32'h200, {6'h32, 26'd3});
        check("pre_rst_branch", {31'd0, branch}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_branch", {31'd0, branch}, 32'd0);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_valid", {31'd0, id_valid}, 32'd0);
        check("midrst_instr", id_instr, 32'h0);
        check("midrst_pc", id_pc, 32'h0);
        #10 rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
